// File: rtl/led_cmd_serializer_if.sv
// Command handshake between an LED command source and the serializer.
// The source owns the command fields and valid; the serializer owns ready.
interface led_cmd_serializer_if;
    logic [4:0] cmd_addr;
    logic       cmd_active;
    logic       cmd_pattern;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (
        output cmd_addr,
        output cmd_active,
        output cmd_pattern,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_addr,
        input  cmd_active,
        input  cmd_pattern,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/led_cmd_serializer.sv
// Turns one parallel LED command into a 7-bit MSB-first frame on s_clk/s_data,
// followed by an s_latch strobe. Out-of-range addresses are rejected with err.
module led_cmd_serializer #(
    parameter int HALF_PERIOD  = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int LED_TOT      = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_cmd_serializer_if.slave  cmd,
    output logic                 s_clk,
    output logic                 s_data,
    output logic                 s_latch,
    output logic                 done,
    output logic                 err
);
    localparam int PMAX = (HALF_PERIOD > LATCH_CYCLES) ? HALF_PERIOD : LATCH_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] HP_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] LC_LAST = PW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   phase_reg, phase_next;
    logic [2:0]      bit_reg, bit_next;
    logic [6:0]      frame_reg, frame_next;
    logic            ready_reg, s_clk_reg, s_data_reg, s_latch_reg, done_reg, err_reg;
    logic            done_next, err_next;
    logic            accept, addr_ok;

    assign accept  = cmd.cmd_valid & ready_reg;
    assign addr_ok = (32'(cmd.cmd_addr) < LED_TOT);

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        frame_next = frame_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (addr_ok) begin
                        frame_next = {cmd.cmd_pattern, cmd.cmd_active, cmd.cmd_addr};
                        bit_next   = 3'd6;
                        phase_next = '0;
                        state_next = LOW;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOW: begin
                if (phase_reg == HP_LAST) begin
                    phase_next = '0;
                    state_next = HIGH;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            HIGH: begin
                if (phase_reg == HP_LAST) begin
                    phase_next = '0;
                    // Bit 0 finishes the frame; the counter never wraps below it.
                    if (bit_reg == 3'd0) begin
                        state_next = LATCH;
                    end else begin
                        bit_next   = bit_reg - 3'd1;
                        state_next = LOW;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            LATCH: begin
                if (phase_reg == LC_LAST) begin
                    phase_next = '0;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            bit_reg     <= 3'd0;
            frame_reg   <= 7'd0;
            ready_reg   <= 1'b0;
            s_clk_reg   <= 1'b0;
            s_data_reg  <= 1'b0;
            s_latch_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bit_reg     <= bit_next;
            frame_reg   <= frame_next;
            ready_reg   <= (state_next == IDLE);
            s_clk_reg   <= (state_next == HIGH);
            s_data_reg  <= ((state_next == LOW) || (state_next == HIGH)) & frame_next[bit_next];
            s_latch_reg <= (state_next == LATCH);
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign cmd.cmd_ready = ready_reg;
    assign s_clk         = s_clk_reg;
    assign s_data        = s_data_reg;
    assign s_latch       = s_latch_reg;
    assign done          = done_reg;
    assign err           = err_reg;
endmodule
